// File: rtl/usb_pkg.sv
// Shared types and constants for the device-side USB protocol FSM.
package usb_pkg;

  localparam logic [3:0] PID_OUT  = 4'b0001;
  localparam logic [3:0] PID_IN   = 4'b1001;
  localparam logic [3:0] PID_DATA = 4'b0011;
  localparam logic [3:0] PID_ACK  = 4'b0010;
  localparam logic [3:0] PID_NAK  = 4'b1010;

  typedef struct packed {
    logic [3:0]  pid;
    logic [3:0]  endp;
    logic [6:0]  addr;
    logic [63:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IN_TX,
    ST_IN_HS,
    ST_OUT_RX,
    ST_HS_TX
  } state_t;

  // Assemble an outgoing packet.
  function automatic pkt_t make_pkt(input logic [3:0] pid, input logic [6:0] addr,
                                    input logic [3:0] endp, input logic [63:0] data);
    pkt_t p;
    p.pid  = pid;
    p.addr = addr;
    p.endp = endp;
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/usb_device_protocol_fsm.sv
// Device-side USB responder for one address/endpoint: serves IN with DATA
// (retrying on NAK/timeout) and accepts OUT DATA with ACK/NAK.
module usb_device_protocol_fsm
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'd5,
  parameter logic [3:0] DEV_ENDP    = 4'd4,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         MAX_RETRY   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_received,
  input  logic        crc_correct,
  input  pkt_t        pkt_in,
  input  logic        pkt_sent,
  input  logic [63:0] in_data,
  input  logic        in_data_valid,
  output logic        encode,
  output logic        kill,
  output logic        decode,
  output pkt_t        pkt_out,
  output logic [63:0] out_data,
  output logic        out_done,
  output logic        in_done,
  output logic        failure
);

  localparam logic [7:0] TO_LIM    = 8'(TIMEOUT_CYC);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic        retry_q, retry_d;
  logic [7:0]  clk_cnt_q, clk_cnt_d;
  logic [3:0]  to_cnt_q, to_cnt_d;
  logic [3:0]  err_cnt_q, err_cnt_d;
  pkt_t        pkt_out_q, pkt_out_d;
  logic [63:0] out_data_q, out_data_d;
  logic        encode_q, encode_d;
  logic        kill_q, kill_d;
  logic        decode_q, decode_d;
  logic        in_done_q, in_done_d;
  logic        out_done_q, out_done_d;
  logic        failure_q, failure_d;

  logic tok_match;
  logic limit_hit;

  assign tok_match = pkt_received & crc_correct &
                     (pkt_in.addr == DEV_ADDR) & (pkt_in.endp == DEV_ENDP);
  // Limits are checked before any increment, so the counters never wrap.
  assign limit_hit = (err_cnt_q == RETRY_LIM) || (to_cnt_q == RETRY_LIM);

  // Next-state, counter and registered-pulse computation.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    clk_cnt_d  = clk_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_cnt_d  = err_cnt_q;
    pkt_out_d  = pkt_out_q;
    out_data_d = out_data_q;
    encode_d   = 1'b0;
    kill_d     = 1'b0;
    decode_d   = 1'b0;
    in_done_d  = 1'b0;
    out_done_d = 1'b0;
    failure_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        to_cnt_d  = '0;
        err_cnt_d = '0;
        retry_d   = 1'b0;
        if (tok_match && pkt_in.pid == PID_IN) begin
          encode_d = 1'b1;
          kill_d   = 1'b1;
          if (in_data_valid) begin
            pkt_out_d = make_pkt(PID_DATA, DEV_ADDR, DEV_ENDP, in_data);
            state_d   = ST_IN_TX;
          end else begin
            pkt_out_d = make_pkt(PID_NAK, DEV_ADDR, DEV_ENDP, 64'h0);
            state_d   = ST_HS_TX;
          end
        end else if (tok_match && pkt_in.pid == PID_OUT) begin
          decode_d = 1'b1;
          state_d  = ST_OUT_RX;
        end
      end

      ST_IN_TX: begin
        if (pkt_sent) begin
          decode_d  = 1'b1;
          clk_cnt_d = '0;
          state_d   = ST_IN_HS;
        end
      end

      ST_IN_HS: begin
        if (limit_hit) begin
          failure_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (pkt_received) begin
          if (crc_correct && pkt_in.pid == PID_ACK) begin
            in_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            // NAK, bad CRC or unexpected PID: resend the held DATA packet.
            err_cnt_d = err_cnt_q + 4'd1;
            encode_d  = 1'b1;
            kill_d    = 1'b1;
            state_d   = ST_IN_TX;
          end
        end else if (clk_cnt_q == TO_LIM) begin
          to_cnt_d = to_cnt_q + 4'd1;
          encode_d = 1'b1;
          kill_d   = 1'b1;
          state_d  = ST_IN_TX;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end

      ST_OUT_RX: begin
        if (limit_hit) begin
          failure_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (pkt_received) begin
          encode_d = 1'b1;
          kill_d   = 1'b1;
          state_d  = ST_HS_TX;
          if (crc_correct && pkt_in.pid == PID_DATA) begin
            out_data_d = pkt_in.data;
            out_done_d = 1'b1;
            pkt_out_d  = make_pkt(PID_ACK, DEV_ADDR, DEV_ENDP, 64'h0);
            retry_d    = 1'b0;
          end else begin
            err_cnt_d = err_cnt_q + 4'd1;
            pkt_out_d = make_pkt(PID_NAK, DEV_ADDR, DEV_ENDP, 64'h0);
            retry_d   = 1'b1;
          end
        end else if (clk_cnt_q == TO_LIM) begin
          to_cnt_d  = to_cnt_q + 4'd1;
          clk_cnt_d = '0;
          decode_d  = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end

      ST_HS_TX: begin
        if (pkt_sent) begin
          decode_d = 1'b1;
          if (retry_q) begin
            clk_cnt_d = '0;
            state_d   = ST_OUT_RX;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and output registers; reset arms the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      retry_q    <= 1'b0;
      clk_cnt_q  <= '0;
      to_cnt_q   <= '0;
      err_cnt_q  <= '0;
      pkt_out_q  <= '0;
      out_data_q <= '0;
      encode_q   <= 1'b0;
      kill_q     <= 1'b0;
      decode_q   <= 1'b1;
      in_done_q  <= 1'b0;
      out_done_q <= 1'b0;
      failure_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      clk_cnt_q  <= clk_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_cnt_q  <= err_cnt_d;
      pkt_out_q  <= pkt_out_d;
      out_data_q <= out_data_d;
      encode_q   <= encode_d;
      kill_q     <= kill_d;
      decode_q   <= decode_d;
      in_done_q  <= in_done_d;
      out_done_q <= out_done_d;
      failure_q  <= failure_d;
    end
  end

  assign encode   = encode_q;
  assign kill     = kill_q;
  assign decode   = decode_q;
  assign pkt_out  = pkt_out_q;
  assign out_data = out_data_q;
  assign out_done = out_done_q;
  assign in_done  = in_done_q;
  assign failure  = failure_q;

endmodule

// File: tb/tb_usb_device_protocol_fsm.sv
// Scoreboard bench for usb_device_protocol_fsm: stimulus pushes expected
// output events, a negedge monitor pops and compares them.
module tb_usb_device_protocol_fsm;
  import usb_pkg::*;

  localparam logic [6:0] DA = 7'd5;
  localparam logic [3:0] DE = 4'd4;
  localparam logic [1:0] K_ENC = 2'd0, K_IND = 2'd1, K_OUTD = 2'd2, K_FAILV = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  pid;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_received = 1'b0;
  logic        crc_correct = 1'b0;
  pkt_t        pkt_in = '0;
  logic        pkt_sent = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_data_valid = 1'b0;
  logic        encode, kill, decode, out_done, in_done, failure;
  pkt_t        pkt_out;
  logic [63:0] out_data;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  tok_cyc = 0;
  int  fail_cyc = 0;
  bit  fail_seen = 0;

  usb_device_protocol_fsm dut (
    .clk(clk), .rst(rst), .pkt_received(pkt_received), .crc_correct(crc_correct),
    .pkt_in(pkt_in), .pkt_sent(pkt_sent), .in_data(in_data), .in_data_valid(in_data_valid),
    .encode(encode), .kill(kill), .decode(decode), .pkt_out(pkt_out), .out_data(out_data),
    .out_done(out_done), .in_done(in_done), .failure(failure)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic observe(input string name, input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: unexpected event %h, nothing expected", name, got);
    end else begin
      e = exp_q.pop_front();
      check(name, 70'(got), 70'(e));
    end
  endtask

  // Monitor: pop one expectation per output pulse, in a fixed per-cycle order.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_done) observe("out_done", '{K_OUTD, 4'h0, out_data});
      if (encode) begin
        observe("encode", '{K_ENC, pkt_out.pid, pkt_out.data});
        check("enc_hdr", 70'({kill, pkt_out.addr, pkt_out.endp}), 70'({1'b1, DA, DE}));
      end
      if (in_done) observe("in_done", '{K_IND, 4'h0, 64'h0});
      if (failure) begin
        observe("failure", '{K_FAILV, 4'h0, 64'h0});
        fail_seen = 1'b1;
        fail_cyc  = cyc;
      end
    end
  end

  task automatic host_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                          input logic [63:0] data, input logic crc);
    @(posedge clk); #1;
    pkt_in       = make_pkt(pid, addr, endp, data);
    pkt_received = 1'b1;
    crc_correct  = crc;
    @(posedge clk); #1;
    tok_cyc      = cyc;
    pkt_received = 1'b0;
    crc_correct  = 1'b0;
  endtask

  task automatic sent();
    @(posedge clk); #1 pkt_sent = 1'b1;
    @(posedge clk); #1 pkt_sent = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] pid, input logic [63:0] d);
    exp_q.push_back('{k, pid, d});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 40000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(3);
    check("rst_decode", 70'(decode), 70'(1));
    check("rst_pulses", 70'({encode, kill, in_done, out_done, failure}), 70'(0));
    check("rst_pkt_out", 70'(pkt_out.data) ^ 70'({pkt_out.pid, pkt_out.addr, pkt_out.endp}), 70'(0));
    check("rst_out_data", 70'(out_data), 70'(0));
    rst = 1'b0;
    idle(1);
    check("decode_one_cycle", 70'(decode), 70'(0));

    // IN with data ready, host ACKs
    in_data = 64'hDEAD_BEEF_0123_4567;
    in_data_valid = 1'b1;
    push(K_ENC, PID_DATA, 64'hDEAD_BEEF_0123_4567);
    host_pkt(PID_IN, DA, DE, 64'h0, 1'b1);
    idle(2);
    sent();
    idle(2);
    push(K_IND, 4'h0, 64'h0);
    host_pkt(PID_ACK, DA, DE, 64'h0, 1'b1);
    idle(3);

    // IN with no data ready: NAK handshake, back to IDLE
    in_data_valid = 1'b0;
    push(K_ENC, PID_NAK, 64'h0);
    host_pkt(PID_IN, DA, DE, 64'h0, 1'b1);
    idle(2);
    sent();
    idle(3);

    // OUT, DATA with bad CRC (NAK), then good DATA 1 (ACK)
    host_pkt(PID_OUT, DA, DE, 64'h0, 1'b1);
    idle(2);
    push(K_ENC, PID_NAK, 64'h0);
    host_pkt(PID_DATA, DA, DE, 64'h55, 1'b0);
    idle(2);
    sent();
    idle(2);
    push(K_OUTD, 4'h0, 64'h1);
    push(K_ENC, PID_ACK, 64'h0);
    host_pkt(PID_DATA, DA, DE, 64'h1, 1'b1);
    idle(2);
    sent();
    idle(3);
    check("out_data_held", 70'(out_data), 70'(64'h1));

    // IN with 8 host NAKs: 8 resends, then failure
    in_data = 64'hA5A5_0000_FFFF_1234;
    in_data_valid = 1'b1;
    push(K_ENC, PID_DATA, 64'hA5A5_0000_FFFF_1234);
    host_pkt(PID_IN, DA, DE, 64'h0, 1'b1);
    idle(2);
    sent();
    idle(2);
    for (int i = 0; i < 8; i++) begin
      push(K_ENC, PID_DATA, 64'hA5A5_0000_FFFF_1234);
      host_pkt(PID_NAK, DA, DE, 64'h0, 1'b1);
      idle(2);
      if (i == 7) push(K_FAILV, 4'h0, 64'h0);
      sent();
      idle(2);
    end
    idle(4);

    // OUT with no DATA: 8 timeouts of 256 cycles, failure one cycle later
    fail_seen = 1'b0;
    push(K_FAILV, 4'h0, 64'h0);
    host_pkt(PID_OUT, DA, DE, 64'h0, 1'b1);
    for (int i = 0; i < 2300 && !fail_seen; i++) idle(1);
    if (!fail_seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL out_timeout: no failure pulse within 2300 cycles, expected after 2049");
    end else begin
      check("out_timeout_cycles", 70'(fail_cyc - tok_cyc), 70'(2049));
    end
    idle(3);

    // Token for another address is ignored (monitor flags any encode)
    host_pkt(PID_IN, 7'd6, DE, 64'h0, 1'b1);
    idle(5);

    // Reset while waiting in IN_HS, then a normal IN transaction
    in_data = 64'h0BAD_CAFE_0000_0042;
    push(K_ENC, PID_DATA, 64'h0BAD_CAFE_0000_0042);
    host_pkt(PID_IN, DA, DE, 64'h0, 1'b1);
    idle(2);
    sent();
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_pulses", 70'({encode, kill, in_done, out_done, failure, decode}), 70'(1));
    check("mid_rst_out_data", 70'(out_data), 70'(0));
    check("mid_rst_pkt_out", 70'(pkt_out.pid), 70'(0));
    idle(2);
    in_data = 64'h1111_2222_3333_4444;
    push(K_ENC, PID_DATA, 64'h1111_2222_3333_4444);
    host_pkt(PID_IN, DA, DE, 64'h0, 1'b1);
    idle(2);
    sent();
    idle(2);
    push(K_IND, 4'h0, 64'h0);
    host_pkt(PID_ACK, DA, DE, 64'h0, 1'b1);
    idle(5);

    check("scoreboard_drained", 70'(exp_q.size()), 70'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
